// File: rtl/shift_add_multiplier_if.sv
// Request/response bundle for the iterative shift-add multiplier.
// The master issues operands and commands; the slave reports busy, done and result.
interface shift_add_multiplier_if;
   logic        start;
   logic        flush;
   logic [31:0] a;
   logic [31:0] b;
   logic        signed1;
   logic        signed2;
   logic        half_sel;
   logic        busy;
   logic        done;
   logic [31:0] result;

   modport master (
      output start, flush, a, b, signed1, signed2, half_sel,
      input  busy, done, result
   );

   modport slave (
      input  start, flush, a, b, signed1, signed2, half_sel,
      output busy, done, result
   );
endinterface

// File: rtl/shift_add_multiplier.sv
// 32x32 sequential multiplier: operand magnitudes are multiplied by shift-add over
// 32 fixed cycles, the sign is applied at the end, and one product half is returned.
module shift_add_multiplier (
   input  logic                        clk,
   input  logic                        rst,
   shift_add_multiplier_if.slave       bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [63:0] acc_q, acc_d;
   logic        neg_q, neg_d;
   logic        half_q, half_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] result_q, result_d;

   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [63:0] product;

   // Negating 0x80000000 wraps to itself, which is the correct unsigned magnitude.
   assign mag_a   = (bus.signed1 && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
   assign mag_b   = (bus.signed2 && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
   assign product = neg_q ? (64'd0 - acc_q) : acc_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      half_d   = half_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.start && !bus.flush) begin
               mcand_d  = {32'd0, mag_a};
               mplier_d = mag_b;
               acc_d    = 64'd0;
               cnt_d    = 6'd0;
               neg_d    = (bus.signed1 & bus.a[31]) ^ (bus.signed2 & bus.b[31]);
               half_d   = bus.half_sel;
               busy_d   = 1'b1;
               state_d  = CALC;
            end
         end
         CALC: begin
            if (bus.flush) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (cnt_q == 6'd32) begin
               // All 32 partial products are in; sign-correct and publish.
               result_d = half_q ? product[63:32] : product[31:0];
               done_d   = 1'b1;
               state_d  = DONE;
            end else begin
               if (mplier_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 6'd1;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 6'd0;
         mcand_q  <= 64'd0;
         mplier_q <= 32'd0;
         acc_q    <= 64'd0;
         neg_q    <= 1'b0;
         half_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         half_q   <= half_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 flush  input  1  abort the operation in flight; the pipeline is squashing the instruction.
REQ-006 a  input  32  multiplicand (rs1 value).
REQ-007 b  input  32  multiplier (rs2 value).
REQ-008 signed1  input  1  1 = treat a as two's complement; 0 = unsigned.
REQ-009 signed2  input  1  1 = treat b as two's complement; 0 = unsigned.
REQ-010 half_sel  input  1  0 = return product[31:0]; 1 = return product[63:32].
REQ-011 busy  output  1  high while an operation is accepted and not yet completed.
REQ-012 done  output  1  one-cycle pulse; result is valid in the same cycle.
REQ-013 result  output  32  selected product half; held stable from done until the next accepted start.

Function
REQ-014 FSM states SHALL be IDLE, CALC and DONE.
REQ-015 IDLE with start=1 and flush=0: latch a, b, signed1, signed2 and half_sel, then go to CALC.
REQ-016 Operand inputs SHALL be ignored after the start cycle.
REQ-017 Latch operand magnitudes: |a| when signed1 and a[31] are both set, otherwise a; b likewise with signed2.
REQ-018 The 32-bit magnitude of 0x80000000 SHALL be 0x80000000 (unsigned).
REQ-019 Latch neg = (signed1 & a[31]) ^ (signed2 & b[31]).
REQ-020 CALC SHALL run exactly 32 iterations, one per cycle, driven by a 6-bit counter.
REQ-021 Each iteration: if the current multiplier LSB = 1, add the multiplicand into the 64-bit accumulator; then shift to the next multiplier bit.
REQ-022 There SHALL be no early termination; latency is fixed.
REQ-023 After the 32nd iteration, go to DONE.
REQ-024 On entering DONE, form the product as the two's-complement negation of the 64-bit accumulator when neg=1, otherwise the accumulator unchanged.
REQ-025 On entering DONE, register result = the product half chosen by the latched half_sel.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 Latency: a start sampled at edge E SHALL give done=1 in the cycle following edge E+33.
REQ-028 busy=1 in CALC and DONE; busy=0 in IDLE.
REQ-029 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-030 flush=1 in CALC: go to IDLE at the next edge; no done pulse; result unchanged.
REQ-031 flush=1 in DONE: the done pulse still completes; result updates.
REQ-032 start and flush both high in IDLE: flush wins; no operation accepted.
REQ-033 A new start sampled in IDLE, including the cycle right after DONE, SHALL be accepted.
REQ-034 The signed1/signed2 combinations SHALL be: 1/1 = MUL/MULH; 1/0 = MULHSU; 0/0 = MULHU/MUL.

Reset
REQ-035 rst=1 SHALL force IDLE and clear busy, done, result, accumulator and counter to 0 at the next edge, in any state.
REQ-036 rst SHALL take precedence over start and flush.
REQ-037 After reset mid-operation, no done pulse SHALL occur for the aborted operation.

Verification
REQ-038 a=7, b=6, signed 0/0, half_sel=0, start at edge 0 -> busy high; done=1 one cycle after edge 33; result=0x0000002A.
REQ-039 a=b=0xFFFFFFFF, signed 1/1 -> half_sel=1 gives 0x00000000; half_sel=0 gives 0x00000001.
REQ-040 a=b=0xFFFFFFFF, signed 1/0, half_sel=1 -> result=0xFFFFFFFF (product 0xFFFFFFFF00000001); signed 0/0, half_sel=1 -> 0xFFFFFFFE.
REQ-041 a=b=0x80000000, signed 1/1, half_sel=1 -> result=0x40000000; half_sel=0 -> 0x00000000.
REQ-042 Start, then flush=1 on the 10th CALC cycle -> busy=0 next cycle, no done, result keeps its prior value; a start the following cycle completes normally.
REQ-043 Start, rst=1 on the 20th cycle -> busy=0, done=0, result=0; start pulses during a busy operation are ignored (exactly one done per accepted start).
